// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch unit: owns the PC, issues icache fetches only when a buffer slot
// is guaranteed, and queues returned instructions for IF/ID. `YSYX_22040750_IFU_BUF2_EN selects a 2-entry buffer.
module ysyx_22040750_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_redirect_valid,
  input  logic [31:0] I_redirect_pc,
  output logic [31:0] O_icache_addr,
  output logic        O_icache_rd_req,
  input  logic        I_icache_rd_ready,
  input  logic [31:0] I_icache_inst,
  input  logic        I_icache_rvalid,
  output logic        O_if_valid,
  output logic [31:0] O_if_pc,
  output logic [31:0] O_if_inst,
  input  logic        I_if_ready
);

`ifdef YSYX_22040750_IFU_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        kill;
  } inflight_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  inflight_t   infl_q, infl_d;
  entry_t      fifo_q [DEPTH];
  entry_t      fifo_d [DEPTH];
  logic [1:0]  count_q, count_d;
  logic        started_q;

  logic        infl_busy;
  logic        transfer;
  logic        handshake;
  logic        push;
  logic [2:0]  credit;
  logic [1:0]  wr_idx;
  logic [31:0] redirect_pc_aligned;
  logic        unused_redirect_lsbs;

  assign redirect_pc_aligned  = {I_redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^I_redirect_pc[1:0];

  // A killed fetch still occupies the icache but its data is never buffered,
  // so it must not hold back a buffer slot.
  assign infl_busy = infl_q.valid && !infl_q.kill;

  assign O_if_valid = (count_q != 2'd0) && !I_redirect_valid;
  assign transfer   = O_if_valid && I_if_ready;

  assign credit = 3'(DEPTH) - {1'b0, count_q} - {2'b00, infl_busy} + {2'b00, transfer};

  assign O_icache_addr   = fetch_pc_q;
  assign O_icache_rd_req = started_q && !I_redirect_valid && (credit != 3'd0);
  assign handshake       = O_icache_rd_req && I_icache_rd_ready;
  assign push            = I_icache_rvalid && infl_busy && !I_redirect_valid;

  assign wr_idx = count_q - {1'b0, transfer};

  assign O_if_pc   = fifo_q[0].pc;
  assign O_if_inst = fifo_q[0].inst;

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves one unassigned infers a latch.
  always_comb begin
    fifo_d  = fifo_q;
    count_d = count_q;
    if (transfer) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fifo_d[i] = fifo_q[i + 1];
      end
      count_d = count_d - 2'd1;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == 2'(i)) begin
          fifo_d[i] = '{pc: infl_q.pc, inst: I_icache_inst};
        end
      end
      count_d = count_d + 2'd1;
    end
    if (I_redirect_valid) begin
      count_d = 2'd0;
    end
  end

  always_comb begin
    infl_d = infl_q;
    if (handshake) begin
      infl_d = '{valid: 1'b1, pc: fetch_pc_q, kill: 1'b0};
    end else if (I_icache_rvalid) begin
      // A response with nothing in flight (e.g. orphaned by reset) just falls through.
      infl_d.valid = 1'b0;
    end
    if (I_redirect_valid && infl_d.valid) begin
      infl_d.kill = 1'b1;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (I_redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
    end else if (handshake) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      fetch_pc_q <= RESET_PC;
      infl_q     <= '0;
      count_q    <= 2'd0;
      started_q  <= 1'b0;
      // NOTE: the buffer storage is reset because its head drives O_if_pc /
      // O_if_inst directly, which must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_q     <= infl_d;
      count_q    <= count_d;
      started_q  <= 1'b1;
      fifo_q     <= fifo_d;
    end
  end

endmodule
